// File: rtl/free_list.sv
// Physical-register free list: a circular FIFO of unused register indices that
// hands one register per cycle to rename and marks it busy in the same cycle.
module free_list #(
    parameter  int PHY_RF_DEPTH  = 128,
    parameter  int ARCH_RF_DEPTH = 32,
    localparam int AW            = $clog2(PHY_RF_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_req,
    output logic          alloc_valid,
    output logic [AW-1:0] alloc_addr,
    input  logic          rel_en,
    input  logic [AW-1:0] rel_addr,
    output logic          busy_wr_en,
    output logic [AW-1:0] busy_wr_addr,
    output logic          busy_data,
    output logic [AW:0]   free_count,
    output logic          overflow_err
);

    localparam int        FREE_INIT = PHY_RF_DEPTH - ARCH_RF_DEPTH;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW-1:0] r_mem [PHY_RF_DEPTH];
    logic [AW:0]   r_head;
    logic [AW:0]   r_tail;
    logic          r_ovf;

    logic          w_empty;
    logic          w_full;
    logic          w_alloc;
    logic          w_rel_live;
    logic          w_rel_ok;
    logic          w_rel_drop;

    // Wrap bit distinguishes full from empty when the indices coincide.
    assign w_empty = (r_head == r_tail);
    assign w_full  = (r_head[AW-1:0] == r_tail[AW-1:0]) && (r_head[AW] != r_tail[AW]);

    assign w_alloc    = alloc_req && !w_empty && !rst;
    // Register 0 is the hardwired zero and never re-enters the list.
    assign w_rel_live = rel_en && (rel_addr != '0);
    // A full list still accepts a release when an allocation vacates a slot this cycle.
    assign w_rel_ok   = w_rel_live && (!w_full || w_alloc);
    assign w_rel_drop = w_rel_live && w_full && !w_alloc;

    assign alloc_valid  = !w_empty;
    assign alloc_addr   = r_mem[r_head[AW-1:0]];
    assign busy_wr_en   = w_alloc;
    assign busy_wr_addr = alloc_addr;
    assign busy_data    = 1'b1;
    assign free_count   = r_tail - r_head;
    assign overflow_err = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage is reset on purpose, because the free registers must be
            // present right after reset; non-blocking assignments keep every update
            // in this block sampling pre-edge values.
            for (int i = 0; i < PHY_RF_DEPTH; i++) begin
                r_mem[i] <= (i < FREE_INIT) ? AW'(ARCH_RF_DEPTH + i) : '0;
            end
            r_head <= '0;
            r_tail <= (AW+1)'(FREE_INIT);
            r_ovf  <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_head <= r_head + PTR_ONE;
            end
            if (w_rel_ok) begin
                r_mem[r_tail[AW-1:0]] <= rel_addr;
                r_tail                <= r_tail + PTR_ONE;
            end
            if (w_rel_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: a reference queue of free registers is pushed on
// release and popped/compared whenever the list hands out a register.
module tb_free_list;

    localparam int DEPTH = 128;
    localparam int ARCH  = 32;
    localparam int AW    = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_req;
    logic          alloc_valid;
    logic [AW-1:0] alloc_addr;
    logic          rel_en;
    logic [AW-1:0] rel_addr;
    logic          busy_wr_en;
    logic [AW-1:0] busy_wr_addr;
    logic          busy_data;
    logic [AW:0]   free_count;
    logic          overflow_err;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] sb_q [$];
    logic          exp_ovf;

    free_list dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_addr   (alloc_addr),
        .rel_en       (rel_en),
        .rel_addr     (rel_addr),
        .busy_wr_en   (busy_wr_en),
        .busy_wr_addr (busy_wr_addr),
        .busy_data    (busy_data),
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge; outputs are sampled
    // 2 units later, well before the next edge, then the model advances.
    task automatic step(input logic req, input logic rel, input logic [AW-1:0] ra);
        logic exp_alloc;
        logic [AW-1:0] got;
        alloc_req = req;
        rel_en    = rel;
        rel_addr  = ra;
        #2;
        exp_alloc = req && (sb_q.size() > 0);
        chk("alloc_valid", int'(alloc_valid), int'(sb_q.size() > 0));
        chk("busy_wr_en", int'(busy_wr_en), int'(exp_alloc));
        chk("free_count", int'(free_count), sb_q.size());
        chk("overflow_err", int'(overflow_err), int'(exp_ovf));
        chk("busy_data", int'(busy_data), 1);
        if (sb_q.size() > 0) begin
            chk("alloc_addr", int'(alloc_addr), int'(sb_q[0]));
            chk("busy_wr_addr", int'(busy_wr_addr), int'(sb_q[0]));
        end
        @(posedge clk);
        if (exp_alloc) got = sb_q.pop_front();
        if (rel && ra != '0) begin
            if (sb_q.size() < DEPTH || exp_alloc) sb_q.push_back(ra);
            else exp_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        alloc_req = 1'b1;
        rel_en    = 1'b1;
        rel_addr  = 7'd9;
        #2;
        chk("busy_wr_en_in_reset", int'(busy_wr_en), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        for (int i = 0; i < DEPTH - ARCH; i++) sb_q.push_back(AW'(ARCH + i));
        exp_ovf = 1'b0;
    endtask

    initial begin
        rst = 1'b1; alloc_req = 1'b0; rel_en = 1'b0; rel_addr = '0; exp_ovf = 1'b0;
        @(posedge clk);
        #1;

        // Reset state and drain of the initial 96 registers.
        do_reset();
        alloc_req = 1'b0; rel_en = 1'b0;
        #1;
        chk("reset_free_count", int'(free_count), 96);
        chk("reset_alloc_addr", int'(alloc_addr), 32);
        chk("reset_alloc_valid", int'(alloc_valid), 1);
        chk("reset_overflow", int'(overflow_err), 0);
        #0;
        for (int i = 0; i < 96; i++) begin
            chk("drain_order", int'(alloc_addr), 32 + i);
            step(1'b1, 1'b0, '0);
        end
        step(1'b1, 1'b0, '0);
        chk("empty_count", int'(free_count), 0);
        chk("empty_valid", int'(alloc_valid), 0);

        // Release into an empty list with a simultaneous request: no bypass.
        step(1'b1, 1'b1, 7'd45);
        #1;
        chk("after_empty_rel_valid", int'(alloc_valid), 1);
        chk("after_empty_rel_addr", int'(alloc_addr), 45);

        // Allocate and release together from 96; 7 surfaces after 95 allocations.
        do_reset();
        step(1'b1, 1'b1, 7'd7);
        chk("pair_count", int'(free_count), 96);
        for (int i = 0; i < 95; i++) step(1'b1, 1'b0, '0);
        chk("pair_tail_addr", int'(alloc_addr), 7);

        // Grow to 10 entries, then release register 0.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, AW'(100 + i));
        chk("count_ten", int'(free_count), 10);
        step(1'b0, 1'b1, '0);
        chk("rel_zero_count", int'(free_count), 10);
        chk("rel_zero_ovf", int'(overflow_err), 0);

        // Fill to capacity, then overflow.
        for (int i = 0; i < DEPTH - 10; i++) step(1'b0, 1'b1, AW'((i % 127) + 1));
        chk("full_count", int'(free_count), 128);
        step(1'b0, 1'b1, 7'd60);
        chk("overflow_count", int'(free_count), 128);
        chk("overflow_set", int'(overflow_err), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
        chk("overflow_sticky", int'(overflow_err), 1);
        step(1'b1, 1'b1, 7'd61);
        chk("full_pair_count", int'(free_count), 128);

        // Wrap-around: 300 paired operations on a full list, then random traffic.
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, AW'($urandom_range(1, 127)));
        chk("wrap_count", int'(free_count), 128);
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 127)));

        // Reset mid-stream.
        do_reset();
        alloc_req = 1'b0; rel_en = 1'b0;
        #1;
        chk("midrst_count", int'(free_count), 96);
        chk("midrst_addr", int'(alloc_addr), 32);
        chk("midrst_ovf", int'(overflow_err), 0);
        step(1'b1, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the rename stage. A circular FIFO of unused physical register indices: it hands one free register per cycle to rename and takes back registers freed at commit. On every successful allocation it writes the busy table directly, marking the new destination busy in the same cycle, so the map and rename reads that follow see it as not ready.

## Interface
- `PHY_RF_DEPTH`, 128: number of physical registers; also the FIFO capacity.
- `ARCH_RF_DEPTH`, 32: number of architectural registers. Physical registers 0..ARCH_RF_DEPTH-1 start out as the identity mapping and are not placed in the list at reset.
- AW = $clog2(PHY_RF_DEPTH), derived, not overridable.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alloc_req`  in  1  rename requests one destination register this cycle.
- `alloc_valid`  out  1  list is non-empty; `alloc_addr` is meaningful.
- `alloc_addr`  out  AW  head entry, show-ahead and combinational from state.
- `rel_en`  in  1  commit releases one physical register.
- `rel_addr`  in  AW  register being released.
- `busy_wr_en`  out  1  busy-table write strobe.
- `busy_wr_addr`  out  AW  busy-table write address; equals `alloc_addr`.
- `busy_data`  out  1  constant 1.
- `free_count`  out  AW+1  number of entries currently in the list.
- `overflow_err`  out  1  sticky flag: a release was dropped.

## Operation
- Storage: PHY_RF_DEPTH entries of AW bits. Head and tail pointers are AW+1 bits wide (wrap bit plus index). The list is empty when the pointers are equal. It is full when the indices are equal and the wrap bits differ.
- Reset: entry i holds ARCH_RF_DEPTH+i for i in 0..PHY_RF_DEPTH-ARCH_RF_DEPTH-1. Head = 0. Tail = PHY_RF_DEPTH-ARCH_RF_DEPTH.
  - All of this is written in the single reset cycle.
  - Outputs after reset: `free_count` = 96 with default parameters; `alloc_valid` = 1; `alloc_addr` = 32; `overflow_err` = 0.
- Allocation handshake: it fires when `alloc_req` && `alloc_valid`.
  - The head advances by 1 (mod 2·PHY_RF_DEPTH) at the edge.
  - If `alloc_req` is high while the list is empty, nothing happens. Rename must stall.
- Busy write: `busy_wr_en` = `alloc_req` && `alloc_valid`, combinational. `busy_wr_addr` = `alloc_addr`. `busy_data` = 1. The busy table captures the write on the same edge as the allocation.
- Release:
  - When `rel_en` is high, `rel_addr` is written at tail and tail advances.
  - `rel_addr` == 0 is ignored: register 0 is the hardwired zero and is never freed.
  - A release when the list is full is dropped and sets `overflow_err`. The flag is cleared only by `rst`.
- Simultaneous allocate and release in one cycle:
  - Both take effect and `free_count` is unchanged.
  - If the list is empty, only the release happens. There is no bypass from `rel_addr` to `alloc_addr`.
  - If the list is full, both happen, because the allocation frees a slot in the same cycle.
- `free_count` update: +1 on release only, −1 on allocation only, unchanged for both or neither. It never exceeds PHY_RF_DEPTH and never drops below 0.
- There are no duplicate-release checks. Commit guarantees that each register is released once.

## Timing
- `alloc_addr`, `alloc_valid`, `busy_wr_*`: zero-latency combinational outputs from the registered pointers plus `alloc_req`.
- An entry released in cycle N can be allocated in cycle N+1 at the earliest, and only once the head reaches it.
- Wrap-around: the pointer index rolls from PHY_RF_DEPTH-1 to 0 and the wrap bit toggles. The entry order is preserved across the wrap.
- `rst` asserted mid-operation overrides any allocation or release in that cycle. During the reset cycle `busy_wr_en` is 0 regardless of `alloc_req`. The list is reinitialised as above.

## Test plan
- Reset, then hold `alloc_req`=1 for 96 cycles.
  - Required: `alloc_addr` runs 32..127 in order, with one `busy_wr_en` per cycle at those addresses.
  - Then `alloc_valid`=0, `free_count`=0, and no further busy writes.
- Empty list: release 45 while `alloc_req`=1 in the same cycle.
  - Required: no allocation that cycle.
  - Next cycle: `alloc_valid`=1 and `alloc_addr`=45.
- Starting with `free_count`=96: allocate and release 7 together.
  - Required: `free_count` stays at 96, and 7 appears at the tail after 95 more allocations.
- Release 0 while `free_count`=10.
  - Required: `free_count` stays at 10 and `overflow_err` stays at 0.
- Fill to 128 with releases, then issue one more release (value 60) alone.
  - Required: `free_count` stays at 128 and `overflow_err`=1, holding until `rst`.
  - Then allocate and release in the same cycle: both are accepted and the count stays at 128.
- Wrap-around: cycle 300 alloc/release pairs.
  - Required: the FIFO order matches a reference queue throughout.
  - Then assert `rst` mid-stream: next cycle `free_count`=96, `alloc_addr`=32 and `overflow_err`=0.
